// File: rtl/decode_pkg.sv
// Instruction field layout, ALU op encoding and the decoder shared by the
// decode/execute pipeline.
package decode_pkg;

  localparam int unsigned ILEN    = 32;
  localparam int unsigned OPC_LSB = 0;
  localparam int unsigned OPC_W   = 7;
  localparam int unsigned RD_LSB  = 7;
  localparam int unsigned F3_LSB  = 12;
  localparam int unsigned F3_W    = 3;
  localparam int unsigned RS1_LSB = 15;
  localparam int unsigned RS2_LSB = 20;
  localparam int unsigned F7_LSB  = 25;
  localparam int unsigned F7_W    = 7;
  localparam int unsigned IMM_LSB = 20;
  localparam int unsigned IMM_W   = 12;
  localparam int unsigned REG_FW  = 5;

  localparam logic [OPC_W-1:0] OPC_OP    = 7'b0110011;
  localparam logic [OPC_W-1:0] OPC_OPIMM = 7'b0010011;
  localparam logic [F7_W-1:0]  F7_BASE   = 7'b0000000;
  localparam logic [F7_W-1:0]  F7_ALT    = 7'b0100000;

  typedef enum logic [3:0] {
    ALU_ADD, ALU_SUB, ALU_SLL, ALU_SLT, ALU_SLTU,
    ALU_XOR, ALU_SRL, ALU_SRA, ALU_OR,  ALU_AND
  } alu_op_e;

  typedef struct packed {
    alu_op_e alu_op;
    logic    use_imm;
    logic    illegal;
  } dec_t;

  // Any register index outside the implemented file makes the instruction illegal.
  function automatic dec_t decode(input logic [ILEN-1:0] instr, input int unsigned nregs);
    dec_t              d;
    logic [OPC_W-1:0]  opc;
    logic [F3_W-1:0]   f3;
    logic [F7_W-1:0]   f7;
    logic              rd_bad;
    logic              rs1_bad;
    logic              rs2_bad;
    opc     = instr[OPC_LSB +: OPC_W];
    f3      = instr[F3_LSB +: F3_W];
    f7      = instr[F7_LSB +: F7_W];
    rd_bad  = 32'(instr[RD_LSB +: REG_FW]) >= nregs;
    rs1_bad = 32'(instr[RS1_LSB +: REG_FW]) >= nregs;
    rs2_bad = 32'(instr[RS2_LSB +: REG_FW]) >= nregs;
    d.alu_op  = ALU_ADD;
    d.use_imm = 1'b0;
    d.illegal = 1'b0;
    if (opc == OPC_OP) begin
      if (f7 == F7_BASE) begin
        case (f3)
          3'd0:    d.alu_op = ALU_ADD;
          3'd1:    d.alu_op = ALU_SLL;
          3'd2:    d.alu_op = ALU_SLT;
          3'd3:    d.alu_op = ALU_SLTU;
          3'd4:    d.alu_op = ALU_XOR;
          3'd5:    d.alu_op = ALU_SRL;
          3'd6:    d.alu_op = ALU_OR;
          default: d.alu_op = ALU_AND;
        endcase
      end else if (f7 == F7_ALT && f3 == 3'd0) begin
        d.alu_op = ALU_SUB;
      end else if (f7 == F7_ALT && f3 == 3'd5) begin
        d.alu_op = ALU_SRA;
      end else begin
        d.illegal = 1'b1;
      end
      if (rd_bad || rs1_bad || rs2_bad) d.illegal = 1'b1;
    end else if (opc == OPC_OPIMM && f3 == 3'd0) begin
      d.use_imm = 1'b1;
      if (rd_bad || rs1_bad) d.illegal = 1'b1;
    end else begin
      d.illegal = 1'b1;
    end
    return d;
  endfunction

endpackage

// File: rtl/exec_alu.sv
// Combinational integer ALU; results wrap modulo 2^XLEN.
module exec_alu
  import decode_pkg::*;
#(
  parameter int unsigned XLEN = 32
) (
  input  alu_op_e         op,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  output logic [XLEN-1:0] result_c
);

  localparam int unsigned SH_W = $clog2(XLEN);

  logic [SH_W-1:0] sh;
  assign sh = b[SH_W-1:0];

  always_comb begin
    result_c = '0;
    case (op)
      ALU_ADD:  result_c = a + b;
      ALU_SUB:  result_c = a - b;
      ALU_SLL:  result_c = a << sh;
      ALU_SLT:  result_c = XLEN'($signed(a) < $signed(b));
      ALU_SLTU: result_c = XLEN'(a < b);
      ALU_XOR:  result_c = a ^ b;
      ALU_SRL:  result_c = a >> sh;
      ALU_SRA:  result_c = XLEN'($signed(a) >>> sh);
      ALU_OR:   result_c = a | b;
      ALU_AND:  result_c = a & b;
      default:  result_c = '0;
    endcase
  end

endmodule

// File: rtl/decode_execute_pipe.sv
// Two-stage issue/execute + retire pipeline with an internal register file
// and S1/S2 operand forwarding.
module decode_execute_pipe
  import decode_pkg::*;
#(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned NREGS = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_instr,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [4:0]      out_rd,
  output logic [XLEN-1:0] out_result,
  output logic            out_illegal
);

  localparam int unsigned RA_W = $clog2(NREGS);

  logic [XLEN-1:0] rf_q [NREGS];
  logic [XLEN-1:0] rf_d [NREGS];

  logic            s1_valid_q, s1_valid_d;
  alu_op_e         s1_op_q, s1_op_d;
  logic [XLEN-1:0] s1_a_q, s1_a_d;
  logic [XLEN-1:0] s1_b_q, s1_b_d;
  logic [RA_W-1:0] s1_rd_q, s1_rd_d;
  logic            s1_ill_q, s1_ill_d;

  logic            s2_valid_q, s2_valid_d;
  logic [XLEN-1:0] s2_result_q, s2_result_d;
  logic [RA_W-1:0] s2_rd_q, s2_rd_d;
  logic            s2_ill_q, s2_ill_d;

  dec_t            dec;
  logic [RA_W-1:0] rs1_idx, rs2_idx, rd_idx;
  logic [XLEN-1:0] imm_sext;
  logic [XLEN-1:0] opa, opb;
  logic [XLEN-1:0] alu_y;
  logic            adv_c;
  logic            s1_fwd_ok, s2_fwd_ok;

  assign dec      = decode(in_instr, NREGS);
  assign rs1_idx  = RA_W'(in_instr[RS1_LSB +: REG_FW]);
  assign rs2_idx  = RA_W'(in_instr[RS2_LSB +: REG_FW]);
  assign rd_idx   = RA_W'(in_instr[RD_LSB +: REG_FW]);
  assign imm_sext = XLEN'($signed(in_instr[IMM_LSB +: IMM_W]));

  assign adv_c     = !s2_valid_q || out_ready;
  assign s1_fwd_ok = s1_valid_q && !s1_ill_q && (s1_rd_q != '0);
  assign s2_fwd_ok = s2_valid_q && !s2_ill_q && (s2_rd_q != '0);

  exec_alu #(.XLEN(XLEN)) u_alu (
    .op       (s1_op_q),
    .a        (s1_a_q),
    .b        (s1_b_q),
    .result_c (alu_y)
  );

  // Operand read: youngest in-flight producer wins over older ones and the file.
  always_comb begin
    if (s1_fwd_ok && s1_rd_q == rs1_idx)      opa = alu_y;
    else if (s2_fwd_ok && s2_rd_q == rs1_idx) opa = s2_result_q;
    else                                      opa = rf_q[rs1_idx];
    if (dec.use_imm)                          opb = imm_sext;
    else if (s1_fwd_ok && s1_rd_q == rs2_idx) opb = alu_y;
    else if (s2_fwd_ok && s2_rd_q == rs2_idx) opb = s2_result_q;
    else                                      opb = rf_q[rs2_idx];
  end

  always_comb begin
    s1_valid_d  = s1_valid_q;
    s1_op_d     = s1_op_q;
    s1_a_d      = s1_a_q;
    s1_b_d      = s1_b_q;
    s1_rd_d     = s1_rd_q;
    s1_ill_d    = s1_ill_q;
    s2_valid_d  = s2_valid_q;
    s2_result_d = s2_result_q;
    s2_rd_d     = s2_rd_q;
    s2_ill_d    = s2_ill_q;
    rf_d        = rf_q;
    if (adv_c) begin
      s1_valid_d = in_valid;
      if (in_valid) begin
        s1_op_d  = dec.alu_op;
        s1_a_d   = opa;
        s1_b_d   = opb;
        s1_rd_d  = rd_idx;
        s1_ill_d = dec.illegal;
      end
      s2_valid_d  = s1_valid_q;
      s2_result_d = s1_ill_q ? '0 : alu_y;
      s2_rd_d     = s1_rd_q;
      s2_ill_d    = s1_ill_q;
    end
    if (s2_valid_q && out_ready && !s2_ill_q && s2_rd_q != '0) begin
      rf_d[s2_rd_q] = s2_result_q;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      s1_valid_q  <= 1'b0;
      s1_op_q     <= ALU_ADD;
      s1_a_q      <= '0;
      s1_b_q      <= '0;
      s1_rd_q     <= '0;
      s1_ill_q    <= 1'b0;
      s2_valid_q  <= 1'b0;
      s2_result_q <= '0;
      s2_rd_q     <= '0;
      s2_ill_q    <= 1'b0;
      rf_q        <= '{default: '0};
    end else begin
      s1_valid_q  <= s1_valid_d;
      s1_op_q     <= s1_op_d;
      s1_a_q      <= s1_a_d;
      s1_b_q      <= s1_b_d;
      s1_rd_q     <= s1_rd_d;
      s1_ill_q    <= s1_ill_d;
      s2_valid_q  <= s2_valid_d;
      s2_result_q <= s2_result_d;
      s2_rd_q     <= s2_rd_d;
      s2_ill_q    <= s2_ill_d;
      rf_q        <= rf_d;
    end
  end

  assign in_ready    = adv_c;
  assign out_valid   = s2_valid_q;
  assign out_rd      = 5'(s2_rd_q);
  assign out_result  = s2_result_q;
  assign out_illegal = s2_ill_q;

endmodule

// File: tb/tb_decode_execute_pipe.sv
// Directed bench for decode_execute_pipe: a 32-register instance plus a
// 16-register instance sharing the same input stream.
module tb_decode_execute_pipe;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic [31:0] in_instr;
  logic        out_ready;

  logic        in_ready,    in_ready_b;
  logic        out_valid,   out_valid_b;
  logic [4:0]  out_rd,      out_rd_b;
  logic [31:0] out_result,  out_result_b;
  logic        out_illegal, out_illegal_b;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  decode_execute_pipe #(.XLEN(32), .NREGS(32)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .in_instr(in_instr), .out_valid(out_valid), .out_ready(out_ready),
    .out_rd(out_rd), .out_result(out_result), .out_illegal(out_illegal)
  );

  decode_execute_pipe #(.XLEN(32), .NREGS(16)) dut16 (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready_b),
    .in_instr(in_instr), .out_valid(out_valid_b), .out_ready(out_ready),
    .out_rd(out_rd_b), .out_result(out_result_b), .out_illegal(out_illegal_b)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] enc_r(input logic [6:0] f7, input logic [2:0] f3,
                                        input logic [4:0] rd, input logic [4:0] rs1,
                                        input logic [4:0] rs2);
    return {f7, rs2, rs1, f3, rd, 7'b0110011};
  endfunction

  function automatic logic [31:0] enc_i(input logic [11:0] imm, input logic [4:0] rd,
                                        input logic [4:0] rs1);
    return {imm, rs1, 3'b000, rd, 7'b0010011};
  endfunction

  // One isolated instruction; returns at the negedge where it is on out_*.
  task automatic issue1(input logic [31:0] instr);
    @(negedge clk);
    in_valid = 1'b1;
    in_instr = instr;
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
  endtask

  logic [31:0] alu_instr [9];
  logic [31:0] alu_exp   [9];
  string       alu_tag   [9];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    reset     = 1'b1;
    in_valid  = 1'b0;
    in_instr  = '0;
    out_ready = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check_eq("rst_out_valid",   out_valid,   0);
    check_eq("rst_out_rd",      out_rd,      0);
    check_eq("rst_out_result",  out_result,  0);
    check_eq("rst_out_illegal", out_illegal, 0);
    check_eq("rst_in_ready",    in_ready,    1);

    // Back-to-back chain exercising S1 and S2 forwarding
    in_valid = 1'b1;
    in_instr = enc_i(12'd5, 5'd1, 5'd0);
    @(negedge clk);
    in_instr = enc_i(12'hFFD, 5'd2, 5'd0);
    @(negedge clk);
    check_eq("fwd_addi_x1", out_result, 32'd5);
    in_instr = enc_r(7'h00, 3'd0, 5'd3, 5'd1, 5'd2);
    @(negedge clk);
    check_eq("fwd_addi_x2", out_result, 32'hFFFFFFFD);
    in_valid = 1'b0;
    @(negedge clk);
    check_eq("fwd_add_x3",    out_result, 32'd2);
    check_eq("fwd_add_x3_rd", out_rd,     32'd3);
    check_eq("fwd_add_valid", out_valid,  1);

    alu_instr[0] = enc_r(7'h20, 3'd0, 5'd4, 5'd1, 5'd2); alu_exp[0] = 32'd8;        alu_tag[0] = "alu_sub";
    alu_instr[1] = enc_r(7'h00, 3'd2, 5'd4, 5'd2, 5'd1); alu_exp[1] = 32'd1;        alu_tag[1] = "alu_slt";
    alu_instr[2] = enc_r(7'h00, 3'd3, 5'd4, 5'd2, 5'd1); alu_exp[2] = 32'd0;        alu_tag[2] = "alu_sltu";
    alu_instr[3] = enc_r(7'h20, 3'd5, 5'd4, 5'd2, 5'd1); alu_exp[3] = 32'hFFFFFFFF; alu_tag[3] = "alu_sra";
    alu_instr[4] = enc_r(7'h00, 3'd5, 5'd4, 5'd2, 5'd1); alu_exp[4] = 32'h07FFFFFF; alu_tag[4] = "alu_srl";
    alu_instr[5] = enc_r(7'h00, 3'd4, 5'd4, 5'd1, 5'd2); alu_exp[5] = 32'hFFFFFFF8; alu_tag[5] = "alu_xor";
    alu_instr[6] = enc_r(7'h00, 3'd1, 5'd4, 5'd1, 5'd1); alu_exp[6] = 32'h000000A0; alu_tag[6] = "alu_sll";
    alu_instr[7] = enc_r(7'h00, 3'd6, 5'd4, 5'd1, 5'd2); alu_exp[7] = 32'hFFFFFFFD; alu_tag[7] = "alu_or";
    alu_instr[8] = enc_r(7'h00, 3'd7, 5'd4, 5'd1, 5'd2); alu_exp[8] = 32'd5;        alu_tag[8] = "alu_and";
    for (int i = 0; i < 9; i++) begin
      issue1(alu_instr[i]);
      check_eq(alu_tag[i], out_result, alu_exp[i]);
    end

    // Backpressure: A in S2, B (forwarded from A) in S1, consumer stalls 3 cycles
    @(negedge clk);
    in_valid = 1'b1;
    in_instr = enc_i(12'd9, 5'd5, 5'd0);
    @(negedge clk);
    in_instr = enc_r(7'h00, 3'd0, 5'd8, 5'd5, 5'd1);
    @(negedge clk);
    in_valid  = 1'b0;
    out_ready = 1'b0;
    check_eq("bp_first_result", out_result, 32'd9);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check_eq("bp_in_ready",  in_ready,   0);
      check_eq("bp_valid",     out_valid,  1);
      check_eq("bp_hold_res",  out_result, 32'd9);
      check_eq("bp_hold_rd",   out_rd,     32'd5);
    end
    out_ready = 1'b1;
    @(negedge clk);
    check_eq("bp_second_result", out_result, 32'd14);
    check_eq("bp_second_rd",     out_rd,     32'd8);
    @(negedge clk);
    check_eq("bp_drained", out_valid, 0);
    issue1(enc_r(7'h00, 3'd0, 5'd10, 5'd5, 5'd0));
    check_eq("bp_x5_written_once", out_result, 32'd9);

    // x0: write discarded and never forwarded
    @(negedge clk);
    in_valid = 1'b1;
    in_instr = enc_i(12'd7, 5'd0, 5'd0);
    @(negedge clk);
    in_instr = enc_r(7'h00, 3'd0, 5'd6, 5'd0, 5'd0);
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    check_eq("x0_no_forward", out_result, 32'd0);
    issue1(enc_r(7'h00, 3'd0, 5'd7, 5'd6, 5'd0));
    check_eq("x0_no_write", out_result, 32'd0);

    // Illegal opcode
    issue1(32'h00000073);
    check_eq("ill_flag",   out_illegal, 1);
    check_eq("ill_result", out_result,  32'd0);
    check_eq("ill_valid",  out_valid,   1);

    // Out-of-range rd on the 16-entry instance must not alias x4 or forward
    issue1(enc_i(12'd3, 5'd4, 5'd0));
    check_eq("n16_set_x4", out_result_b, 32'd3);
    @(negedge clk);
    in_valid = 1'b1;
    in_instr = enc_i(12'd1, 5'd20, 5'd0);
    @(negedge clk);
    in_instr = enc_r(7'h00, 3'd0, 5'd11, 5'd4, 5'd0);
    @(negedge clk);
    in_valid = 1'b0;
    check_eq("n16_ill_flag",   out_illegal_b, 1);
    check_eq("n16_ill_result", out_result_b,  32'd0);
    check_eq("n32_x20_legal",  out_illegal,   0);
    @(negedge clk);
    check_eq("n16_x4_kept", out_result_b, 32'd3);
    issue1(enc_r(7'h00, 3'd0, 5'd11, 5'd4, 5'd0));
    check_eq("n16_x4_kept_rf", out_result_b, 32'd3);

    // Reset with both stages full
    @(negedge clk);
    in_valid = 1'b1;
    in_instr = enc_i(12'd11, 5'd1, 5'd0);
    @(negedge clk);
    in_instr = enc_i(12'd12, 5'd2, 5'd0);
    @(negedge clk);
    in_valid = 1'b0;
    check_eq("mid_pre_valid", out_valid, 1);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check_eq("mid_rst_valid",  out_valid,  0);
    check_eq("mid_rst_result", out_result, 32'd0);
    @(negedge clk);
    check_eq("mid_post_valid", out_valid, 0);
    check_eq("mid_post_ready", in_ready,  1);
    issue1(enc_r(7'h00, 3'd0, 5'd7, 5'd1, 5'd2));
    check_eq("mid_rf_cleared", out_result, 32'd0);
    check_eq("mid_rf_valid",   out_valid,  1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
